// File: rtl/circuito_jogo_param.sv
// Parametrised "Genius" memory-sequence game core: plays back the stored sequence,
// checks the player's presses and grows the sequence by one element per round.
module circuito_jogo_param #(
    parameter int N_BOTOES       = 4,
    parameter int N_RODADAS      = 16,
    parameter int TIMEOUT_CICLOS = 3000,
    parameter int T_MOSTRA       = 500
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic                modo,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic [3:0]          db_estado,
    output logic [4:0]          db_rodada,
    output logic [4:0]          db_jogada,
    output logic                db_tem_jogada
);

    localparam int LB = $clog2(N_BOTOES);
    localparam int AW = $clog2(N_RODADAS);
    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam int CW = (T_MOSTRA > 1) ? $clog2(T_MOSTRA) : 1;

    localparam logic [TW-1:0]       TIMER_MAX     = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [TW-1:0]       TIMER_UM      = TW'(1);
    localparam logic [CW-1:0]       MOSTRA_MAX    = CW'(T_MOSTRA - 1);
    localparam logic [CW-1:0]       CONT_UM       = CW'(1);
    localparam logic [4:0]          ULTIMA_RODADA = 5'(N_RODADAS - 1);
    localparam logic [N_BOTOES-1:0] BOTAO_UM      = N_BOTOES'(1);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        MOSTRA_LIGA    = 4'h2,
        MOSTRA_DESLIGA = 4'h3,
        ESPERA         = 4'h4,
        COMPARA        = 4'h5,
        FIM_RODADA     = 4'h6,
        ESPERA_ESCRITA = 4'h7,
        PROX_RODADA    = 4'h8,
        FIM_GANHOU     = 4'hA,
        FIM_PERDEU     = 4'hB,
        FIM_TIMEOUT    = 4'hC
    } estado_t;

    estado_t             estado_r;
    logic [15:0]         lfsr_r;
    logic [N_BOTOES-1:0] botoes_r;
    logic [N_BOTOES-1:0] jogada_val_r;
    logic [4:0]          rodada_r;
    logic [4:0]          jogada_r;
    logic [TW-1:0]       timer_r;
    logic [CW-1:0]       cont_r;
    logic                modo_r;
    logic                mem_we_r;
    logic [AW-1:0]       mem_addr_r;
    logic [N_BOTOES-1:0] mem_din_r;
    logic [N_BOTOES-1:0] mem [N_RODADAS];

    logic                evento_s;
    logic                fb_s;
    logic [N_BOTOES-1:0] elemento_s;
    logic [4:0]          jogada_prox_s;
    logic [4:0]          rodada_prox_s;
    logic [N_BOTOES-1:0] mem_atual_s;
    logic [N_BOTOES-1:0] mem_prox_s;

    function automatic logic one_hot(input logic [N_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - BOTAO_UM)) == '0);
    endfunction

    // Enter a state and update every state-derived output on the same edge.
    task automatic ir(input estado_t e);
        estado_r  <= e;
        db_estado <= e;
        pronto    <= (e == FIM_GANHOU) || (e == FIM_PERDEU) || (e == FIM_TIMEOUT);
        ganhou    <= (e == FIM_GANHOU);
        perdeu    <= (e == FIM_PERDEU);
        timeout   <= (e == FIM_TIMEOUT);
        leds      <= '0;
    endtask

    assign evento_s      = (botoes != '0) && (botoes_r == '0);
    assign fb_s          = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    assign elemento_s    = BOTAO_UM << lfsr_r[LB-1:0];
    assign jogada_prox_s = jogada_r + 5'd1;
    assign rodada_prox_s = rodada_r + 5'd1;
    assign mem_atual_s   = mem[jogada_r[AW-1:0]];
    assign mem_prox_s    = mem[jogada_prox_s[AW-1:0]];
    assign db_rodada     = rodada_r;
    assign db_jogada     = jogada_r;

    // Sequence memory; writes are requested one cycle earlier by the FSM.
    always_ff @(posedge clock) begin
        if (mem_we_r) begin
            mem[mem_addr_r] <= mem_din_r;
        end
    end

    // Game FSM, counters, LFSR, press edge detector and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r      <= INICIAL;
            lfsr_r        <= 16'hACE1;
            botoes_r      <= '0;
            jogada_val_r  <= '0;
            rodada_r      <= 5'd0;
            jogada_r      <= 5'd0;
            timer_r       <= '0;
            cont_r        <= '0;
            modo_r        <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_din_r     <= '0;
            leds          <= '0;
            pronto        <= 1'b0;
            ganhou        <= 1'b0;
            perdeu        <= 1'b0;
            timeout       <= 1'b0;
            db_estado     <= 4'h0;
            db_tem_jogada <= 1'b0;
        end else begin
            lfsr_r        <= {lfsr_r[14:0], fb_s};
            botoes_r      <= botoes;
            db_tem_jogada <= evento_s;
            mem_we_r      <= 1'b0;
            case (estado_r)
                INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                    if (jogar) begin
                        modo_r <= modo;
                        ir(PREPARA);
                    end
                end
                PREPARA: begin
                    rodada_r   <= 5'd0;
                    jogada_r   <= 5'd0;
                    timer_r    <= '0;
                    cont_r     <= '0;
                    mem_we_r   <= 1'b1;
                    mem_addr_r <= '0;
                    mem_din_r  <= elemento_s;
                    ir(MOSTRA_LIGA);
                    // mem[0] is written a cycle later, so show the element directly.
                    leds       <= elemento_s;
                end
                MOSTRA_LIGA: begin
                    if (cont_r == MOSTRA_MAX) begin
                        cont_r <= '0;
                        ir(MOSTRA_DESLIGA);
                    end else begin
                        cont_r <= cont_r + CONT_UM;
                    end
                end
                MOSTRA_DESLIGA: begin
                    if (cont_r == MOSTRA_MAX) begin
                        cont_r <= '0;
                        if (jogada_r == rodada_r) begin
                            jogada_r <= 5'd0;
                            timer_r  <= '0;
                            ir(ESPERA);
                        end else begin
                            jogada_r <= jogada_prox_s;
                            ir(MOSTRA_LIGA);
                            leds     <= mem_prox_s;
                        end
                    end else begin
                        cont_r <= cont_r + CONT_UM;
                    end
                end
                ESPERA: begin
                    if (evento_s) begin
                        jogada_val_r <= botoes;
                        ir(COMPARA);
                    end else if (timer_r == TIMER_MAX) begin
                        ir(FIM_TIMEOUT);
                    end else begin
                        timer_r <= timer_r + TIMER_UM;
                    end
                end
                COMPARA: begin
                    if (jogada_val_r != mem_atual_s) begin
                        ir(FIM_PERDEU);
                    end else if (jogada_r != rodada_r) begin
                        jogada_r <= jogada_prox_s;
                        timer_r  <= '0;
                        ir(ESPERA);
                    end else begin
                        ir(FIM_RODADA);
                    end
                end
                FIM_RODADA: begin
                    if (rodada_r == ULTIMA_RODADA) begin
                        ir(FIM_GANHOU);
                    end else if (!modo_r) begin
                        mem_we_r   <= 1'b1;
                        mem_addr_r <= rodada_prox_s[AW-1:0];
                        mem_din_r  <= elemento_s;
                        ir(PROX_RODADA);
                    end else begin
                        timer_r <= '0;
                        ir(ESPERA_ESCRITA);
                    end
                end
                ESPERA_ESCRITA: begin
                    if (evento_s && one_hot(botoes)) begin
                        mem_we_r   <= 1'b1;
                        mem_addr_r <= rodada_prox_s[AW-1:0];
                        mem_din_r  <= botoes;
                        ir(PROX_RODADA);
                    end else if (timer_r == TIMER_MAX) begin
                        ir(FIM_TIMEOUT);
                    end else begin
                        timer_r <= timer_r + TIMER_UM;
                    end
                end
                PROX_RODADA: begin
                    rodada_r <= rodada_prox_s;
                    jogada_r <= 5'd0;
                    timer_r  <= '0;
                    cont_r   <= '0;
                    ir(MOSTRA_LIGA);
                    leds     <= mem[0];
                end
                default: begin
                    ir(INICIAL);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circuito_jogo_param.sv
// Self-checking bench for circuito_jogo_param: plays games against the core and keeps
// a scoreboard of the sequence it entered, compared against each later playback.
module tb_circuito_jogo_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0;
    logic       modo  = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic [3:0] leds;
    logic       pronto, ganhou, perdeu, timeout;
    logic [3:0] db_estado;
    logic [4:0] db_rodada, db_jogada;
    logic       db_tem_jogada;

    int         n_checks = 0;
    int         n_errors = 0;
    int         pulsos   = 0;
    int         base;
    logic [3:0] seq [0:7];
    logic [3:0] exp_q [$];
    logic [3:0] errada;

    circuito_jogo_param #(
        .N_BOTOES(4), .N_RODADAS(3), .TIMEOUT_CICLOS(20), .T_MOSTRA(4)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .modo(modo), .botoes(botoes),
        .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
        .db_estado(db_estado), .db_rodada(db_rodada), .db_jogada(db_jogada),
        .db_tem_jogada(db_tem_jogada)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (db_tem_jogada) pulsos <= pulsos + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_estado(input logic [3:0] e, input string tag);
        int n = 0;
        while (db_estado !== e && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, db_estado, e);
    endtask

    task automatic start_game(input logic m);
        modo  = m;
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        exp_q.delete();
    endtask

    task automatic press(input logic [3:0] v, input bit push);
        if (push) exp_q.push_back(v);
        botoes = v;
        @(negedge clock);
        botoes = 4'b0000;
        @(negedge clock);
    endtask

    // Watch a playback of 'total' elements; the first n_known come from the scoreboard.
    task automatic watch_playback(input int total, input int n_known);
        for (int k = 0; k < total; k++) begin
            int n = 0;
            int lit = 0;
            logic [3:0] v;
            logic [3:0] e;
            while (leds == 4'b0000 && n < 100) begin
                @(negedge clock);
                n++;
            end
            v = leds;
            while (v != 4'b0000 && leds == v && lit < 100) begin
                lit++;
                @(negedge clock);
            end
            check_eq("lit_len", lit, 4);
            if (k < n_known) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
                check_eq("playback", v, e);
            end else begin
                check_eq("new_onehot", $countones(v), 1);
            end
            seq[k] = v;
        end
    endtask

    task automatic play_round(input int r);
        watch_playback(r + 1, r);
        wait_estado(4'h4, "espera");
        for (int k = 0; k <= r; k++) press(seq[k], 1'b1);
    endtask

    task automatic play_to_win(input string tag);
        for (int r = 0; r < 3; r++) play_round(r);
        wait_estado(4'hA, tag);
        check_eq("win_ganhou", ganhou, 1);
        check_eq("win_pronto", pronto, 1);
        check_eq("win_perdeu", perdeu, 0);
        check_eq("win_leds", leds, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_eq("rst_estado", db_estado, 0);
        check_eq("rst_leds", leds, 0);
        check_eq("rst_flags", {pronto, ganhou, perdeu, timeout, db_tem_jogada}, 0);
        check_eq("rst_cnt", {db_rodada, db_jogada}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("idle_estado", db_estado, 0);

        // full win in mode 0
        start_game(1'b0);
        play_to_win("win");

        // wrong element in round 1
        start_game(1'b0);
        play_round(0);
        watch_playback(2, 1);
        wait_estado(4'h4, "espera_l");
        press(seq[0], 1'b1);
        errada = {seq[1][2:0], seq[1][3]};
        press(errada, 1'b0);
        wait_estado(4'hB, "lose");
        check_eq("lose_perdeu", perdeu, 1);
        check_eq("lose_rodada", db_rodada, 1);
        check_eq("lose_ganhou", ganhou, 0);

        // inactivity timeout at exactly TIMEOUT_CICLOS cycles
        start_game(1'b0);
        watch_playback(1, 0);
        wait_estado(4'h4, "espera_t");
        repeat (19) @(negedge clock);
        check_eq("tmo_not_yet", db_estado, 4'h4);
        @(negedge clock);
        check_eq("tmo_estado", db_estado, 4'hC);
        check_eq("tmo_flag", timeout, 1);
        check_eq("tmo_perdeu", perdeu, 0);
        check_eq("tmo_pronto", pronto, 1);

        // press on the expiry cycle wins, then a multi-bit press loses
        start_game(1'b0);
        watch_playback(1, 0);
        wait_estado(4'h4, "espera_x");
        repeat (19) @(negedge clock);
        exp_q.push_back(seq[0]);
        botoes = seq[0];
        @(negedge clock);
        check_eq("expiry_compara", db_estado, 4'h5);
        check_eq("expiry_pulse", db_tem_jogada, 1);
        check_eq("expiry_tmo", timeout, 0);
        botoes = 4'b0000;
        @(negedge clock);
        check_eq("expiry_fimrod", db_estado, 4'h6);
        watch_playback(2, 1);
        wait_estado(4'h4, "espera_m");
        press(4'b0011, 1'b0);
        wait_estado(4'hB, "multi_lose");
        check_eq("multi_perdeu", perdeu, 1);

        // player-written mode
        start_game(1'b1);
        watch_playback(1, 0);
        wait_estado(4'h4, "espera_w");
        press(seq[0], 1'b1);
        wait_estado(4'h7, "escrita");
        press(4'b0011, 1'b0);
        check_eq("escrita_ignora", db_estado, 4'h7);
        press(4'b0100, 1'b1);
        watch_playback(2, 2);
        wait_estado(4'h4, "espera_w1");
        press(seq[0], 1'b1);
        press(seq[1], 1'b1);
        wait_estado(4'h7, "escrita2");

        // held button across two waiting windows yields one event only
        base = pulsos;
        botoes = 4'b0010;
        wait_estado(4'hC, "hold_tmo");
        check_eq("hold_pulses", pulsos - base, 1);
        check_eq("hold_rodada", db_rodada, 2);
        botoes = 4'b0000;
        @(negedge clock);

        // asynchronous reset during playback, then a fresh game
        start_game(1'b0);
        begin
            int n = 0;
            while (leds == 4'b0000 && n < 100) begin
                @(negedge clock);
                n++;
            end
        end
        check_eq("pre_rst_liga", db_estado, 4'h2);
        reset = 1'b0;
        #1;
        check_eq("midrst_leds", leds, 0);
        check_eq("midrst_estado", db_estado, 0);
        check_eq("midrst_pronto", pronto, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        start_game(1'b0);
        play_to_win("win2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/circuito_jogo_param.md
Name: circuito_jogo_param

Overview:
- Parametrised memory-sequence game core, "Genius" style. Successor to the fixed 4-button game top.
- Each round first shows the stored sequence on `leds`, then checks the player's one-hot button presses against it.
- After a correct round one new element is appended. Mode 0: the element comes from an internal LFSR. Mode 1: the player enters it.
- Adds sequence playback, player-written mode, inactivity timeout and multi-press detection. Sits under the board top, which drives the 7-segment decoders from the db_* outputs.

Parameters:
- N_BOTOES, 4, number of buttons/LEDs; legal values 2, 4, 8.
- N_RODADAS, 16, rounds needed to win (2..32); also the sequence memory depth.
- TIMEOUT_CICLOS, 3000, idle cycles allowed while waiting for a press.
- T_MOSTRA, 500, cycles an LED is lit, and also the dark gap after it, during playback.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- jogar  in  1  start/restart pulse; sampled in INICIAL and in the FIM_* states.
- modo  in  1  0 = LFSR appends the new element, 1 = player appends it; latched when jogar is accepted.
- botoes  in  N_BOTOES  buttons; already synchronised and debounced upstream.
- leds  out  N_BOTOES  one-hot playback output; zero outside MOSTRA_LIGA.
- pronto  out  1  high in any FIM_* state.
- ganhou  out  1  high in FIM_GANHOU.
- perdeu  out  1  high in FIM_PERDEU.
- timeout  out  1  high in FIM_TIMEOUT.
- db_estado  out  4  current state code.
- db_rodada  out  5  current round index.
- db_jogada  out  5  current play index within the round.
- db_tem_jogada  out  1  one-cycle pulse when a press is detected.

Behaviour:
- Reset (reset=0): state INICIAL; all outputs 0; round/play/timer counters 0; memory not cleared; LFSR = 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock, free-running. New element = one-hot of lfsr[$clog2(N_BOTOES)-1:0].
- Press detection: botoes registered once. Press event = (botoes != 0) while the previous sample == 0. Only one event per press; held buttons ignored until released to 0.
- Valid press: exactly one bit set. A multi-bit press counts as a wrong play.
- Memory: N_RODADAS x N_BOTOES register array, synchronous write, combinational read.
- State codes and transitions:
  - 0 INICIAL: wait for jogar.
  - 1 PREPARA: clear counters; mem[0] <- LFSR element (both modes); go to 2.
  - 2 MOSTRA_LIGA: leds = mem[jogada] for T_MOSTRA cycles; go to 3.
  - 3 MOSTRA_DESLIGA: leds = 0 for T_MOSTRA cycles. If jogada == rodada, clear jogada and go to 4; else jogada+1 and go to 2.
  - 4 ESPERA: timer counts up. On a press event go to 5. If timer reaches TIMEOUT_CICLOS-1 with no event go to C. A press in the same cycle as expiry wins.
  - 5 COMPARA: press == mem[jogada]? No → B. Yes and jogada < rodada → jogada+1, clear timer, back to 4. Yes and jogada == rodada → 6.
  - 6 FIM_RODADA: if rodada == N_RODADAS-1 go to A. Mode 0: mem[rodada+1] <- LFSR element, then go to 8. Mode 1: clear timer, go to 7.
  - 7 ESPERA_ESCRITA: same timeout rule as ESPERA. A valid press writes mem[rodada+1] <- press and goes to 8. A multi-bit press is ignored (stay in 7).
  - 8 PROX_RODADA: rodada+1; clear jogada and timer; go to 2.
  - A FIM_GANHOU, B FIM_PERDEU, C FIM_TIMEOUT: hold flags. jogar returns to 1 and re-latches modo.
- Each round is played back in full before any input is accepted. Presses during playback are discarded: the edge detector still tracks, but no event is used.
- Flags ganhou/perdeu/timeout/pronto are registered and change on the clock edge that enters or leaves their state.
- Timer width is $clog2(TIMEOUT_CICLOS); it saturates, never wraps. Counters never exceed N_RODADAS-1.
- reset asserted mid-game forces INICIAL immediately, regardless of state.

Test Plan:
- Overrides N_BOTOES=4, N_RODADAS=3, TIMEOUT_CICLOS=20, T_MOSTRA=4; mode 0; jogar. Bench reads each element off leds during MOSTRA and echoes it on botoes over three rounds → ganhou=1, pronto=1, db_estado=A, leds=0.
- Same setup; in round 1 press a button different from mem[1] → perdeu=1, db_estado=B, db_rodada=1.
- Round 0 entered, no press for 20 cycles → timeout=1, perdeu=0, db_estado=C. Repeat with the press landing on the expiry cycle → compare proceeds, no timeout.
- Press 4'b0011 in ESPERA → perdeu=1. In mode 1 ESPERA_ESCRITA, press 4'b0011 then 4'b0100 → first press ignored, mem[1]=4'b0100, round 1 playback shows 4'b0100 second.
- Hold a button across two ESPERA windows → only one db_tem_jogada pulse. Assert reset during MOSTRA_LIGA → leds=0 and db_estado=0 at once. Then jogar → a fresh game runs normally.
